// File: rtl/nand_flash_pkg.sv
// Shared opcodes, FSM state encodings and constants for the NAND command controller.
package nand_flash_pkg;

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_PROG  = 2'b01;
    localparam logic [1:0] OP_ERASE = 2'b10;
    localparam logic [1:0] OP_RSVD  = 2'b11;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_RD_ISSUE = 3'd1;
    localparam logic [2:0] ST_RD_WAIT  = 3'd2;
    localparam logic [2:0] ST_PROG     = 3'd3;
    localparam logic [2:0] ST_ERASE    = 3'd4;
    localparam logic [2:0] ST_RESP     = 3'd5;

    localparam logic [7:0] ERASED_BYTE = 8'hFF;

endpackage

// File: rtl/nand_flash_ctrl_if.sv
// Host request/response channel of the NAND controller (valid/ready both ways).
interface nand_flash_ctrl_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);

    logic              req_valid;
    logic              req_ready;
    logic [1:0]        req_op;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_op, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_op, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/nand_blk_counter.sv
// Byte-offset counter used to walk one erase block; tc flags the last offset.
module nand_blk_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] cnt,
    output logic         tc
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + W'(1);
        end
    end

    assign tc = &cnt;

endmodule

// File: rtl/nand_flash_ctrl.sv
// NAND command controller: sequences read / read-modify-program / block erase.
module nand_flash_ctrl
    import nand_flash_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int BLOCK_W = 4,
    parameter int RD_LAT  = 1
) (
    input  logic              clk,
    input  logic              rst,
    nand_flash_ctrl_if.slave  host,
    output logic              mem_we,
    output logic              mem_re,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int LAT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    logic [2:0]         state_q;
    logic [2:0]         state_d;
    logic [1:0]         op_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [DATA_W-1:0]  wdata_q;
    logic [DATA_W-1:0]  data_q;
    logic               err_q;
    logic [LAT_W-1:0]   lat_q;
    logic               accept;
    logic               lat_done;
    logic               in_erase;
    logic [BLOCK_W-1:0] blk_cnt;
    logic               blk_tc;

    assign host.req_ready = (state_q == ST_IDLE) && !rst;
    assign accept         = host.req_valid && host.req_ready;
    assign lat_done       = (lat_q == '0);
    assign in_erase       = (state_q == ST_ERASE);

    nand_blk_counter #(
        .W(BLOCK_W)
    ) u_blk_cnt (
        .clk(clk),
        .rst(rst),
        .clr(!in_erase),
        .en (in_erase),
        .cnt(blk_cnt),
        .tc (blk_tc)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    unique case (1'b1)
                        (host.req_op == OP_READ),
                        (host.req_op == OP_PROG):  state_d = ST_RD_ISSUE;
                        (host.req_op == OP_ERASE): state_d = ST_ERASE;
                        (host.req_op == OP_RSVD):  state_d = ST_RESP;
                        default:                   state_d = ST_IDLE;
                    endcase
                end
            end
            ST_RD_ISSUE: state_d = ST_RD_WAIT;
            ST_RD_WAIT: begin
                if (lat_done) begin
                    state_d = (op_q == OP_PROG) ? ST_PROG : ST_RESP;
                end
            end
            ST_PROG: state_d = ST_RESP;
            ST_ERASE: begin
                if (blk_tc) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (host.rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            op_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
            lat_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q    <= host.req_op;
                addr_q  <= host.req_addr;
                wdata_q <= host.req_wdata;
                data_q  <= '0;
                err_q   <= (host.req_op == OP_RSVD);
                lat_q   <= LAT_W'(RD_LAT - 1);
            end
            if (state_q == ST_RD_WAIT) begin
                if (lat_done) begin
                    data_q <= mem_rdata;
                    // Programming can only clear bits; any 0->1 request is an error.
                    err_q  <= (op_q == OP_PROG) && |(wdata_q & ~mem_rdata);
                end else begin
                    lat_q <= lat_q - LAT_W'(1);
                end
            end
        end
    end

    always_comb begin
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state_q)
            ST_RD_ISSUE: begin
                mem_re   = 1'b1;
                mem_addr = addr_q;
            end
            ST_PROG: begin
                mem_we    = 1'b1;
                mem_addr  = addr_q;
                mem_wdata = data_q & wdata_q;
            end
            ST_ERASE: begin
                mem_we    = 1'b1;
                mem_addr  = {addr_q[ADDR_W-1:BLOCK_W], blk_cnt};
                mem_wdata = DATA_W'(ERASED_BYTE);
            end
            default: begin
                mem_we = 1'b0;
            end
        endcase
    end

    assign host.rsp_valid = (state_q == ST_RESP);
    assign host.rsp_err   = host.rsp_valid && err_q;
    assign host.rsp_rdata = (host.rsp_valid && op_q == OP_READ) ? data_q : '0;

    a_we_re_excl : assert property (
        @(posedge clk) disable iff (rst) !(mem_we && mem_re));

    a_rsp_hold : assert property (
        @(posedge clk) disable iff (rst)
        host.rsp_valid && !host.rsp_ready |=>
            host.rsp_valid && $stable(host.rsp_rdata) && $stable(host.rsp_err));

    a_no_overlap : assert property (
        @(posedge clk) disable iff (rst) !(host.req_ready && host.rsp_valid));

endmodule
